// File: rtl/turf_wb_byte_bridge.sv
// Byte-framed host commands -> single Wishbone classic cycles; one transaction outstanding, cyc at N+1 after last byte.
// Response (status + read data) is held on m_tdata until m_tready; no command bytes are taken while busy.
module turf_wb_byte_bridge #(
  parameter int NUM_ADDRESS_BITS = 15,
  parameter int TIMEOUT_CYCLES   = 255
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_n_i,
  input  logic [7:0]                  s_tdata,
  input  logic                        s_tvalid,
  output logic                        s_tready,
  output logic [7:0]                  m_tdata,
  output logic                        m_tvalid,
  input  logic                        m_tready,
  output logic                        wb_cyc_o,
  output logic                        wb_stb_o,
  output logic                        wb_we_o,
  output logic [NUM_ADDRESS_BITS-1:0] wb_adr_o,
  output logic [31:0]                 wb_dat_o,
  output logic [3:0]                  wb_sel_o,
  input  logic [31:0]                 wb_dat_i,
  input  logic                        wb_ack_i,
  input  logic                        wb_err_i,
  input  logic                        wb_rty_i,
  output logic                        busy_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {CMD0, CMD1, DATA, WB, RESP} state_t;

  state_t        state_q;
  logic          w_q;
  logic [14:0]   adr_q;
  logic [31:0]   dat_q;
  logic [31:0]   rd_q;
  logic [2:0]    cnt_q;
  logic [TW-1:0] tmo_q;
  logic          cyc_q;
  logic          we_q;
  logic          s_tready_q;
  logic          m_tvalid_q;
  logic [7:0]    m_tdata_q;

  logic s_acc;
  logic m_acc;
  logic term;

  assign s_acc = s_tvalid && s_tready_q;
  assign m_acc = m_tvalid_q && m_tready;
  assign term  = wb_ack_i || wb_err_i || wb_rty_i;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q    <= CMD0;
      w_q        <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      tmo_q      <= '0;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      s_tready_q <= 1'b1;
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
    end else begin
      case (state_q)
        CMD0: if (s_acc) begin
          w_q         <= s_tdata[7];
          adr_q[14:8] <= s_tdata[6:0];
          state_q     <= CMD1;
        end
        CMD1: if (s_acc) begin
          adr_q[7:0] <= s_tdata;
          cnt_q      <= '0;
          tmo_q      <= '0;
          if (w_q) begin
            state_q <= DATA;
          end else begin
            state_q    <= WB;
            cyc_q      <= 1'b1;
            s_tready_q <= 1'b0;
          end
        end
        DATA: if (s_acc) begin
          dat_q <= {dat_q[23:0], s_tdata};
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd3) begin
            state_q    <= WB;
            cyc_q      <= 1'b1;
            we_q       <= 1'b1;
            s_tready_q <= 1'b0;
            tmo_q      <= '0;
          end
        end
        WB: begin
          tmo_q <= tmo_q + 1'b1;
          // A termination on the expiry edge is honoured; the timeout only fires without one.
          if (term || tmo_q == TMO_LAST) begin
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            m_tvalid_q <= 1'b1;
            cnt_q      <= '0;
            state_q    <= RESP;
            if (wb_err_i) begin
              m_tdata_q <= 8'h01;
              rd_q      <= '0;
            end else if (wb_rty_i) begin
              m_tdata_q <= 8'h02;
              rd_q      <= '0;
            end else if (wb_ack_i) begin
              m_tdata_q <= 8'h00;
              rd_q      <= wb_dat_i;
            end else begin
              m_tdata_q <= 8'h03;
              rd_q      <= '0;
            end
          end
        end
        RESP: if (m_acc) begin
          if (cnt_q == (w_q ? 3'd0 : 3'd4)) begin
            m_tvalid_q <= 1'b0;
            s_tready_q <= 1'b1;
            state_q    <= CMD0;
          end else begin
            m_tdata_q <= rd_q[31:24];
            rd_q      <= {rd_q[23:0], 8'h00};
            cnt_q     <= cnt_q + 3'd1;
          end
        end
        default: state_q <= CMD0;
      endcase
    end
  end

  assign s_tready = s_tready_q;
  assign m_tvalid = m_tvalid_q;
  assign m_tdata  = m_tdata_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o  = we_q;
  assign wb_adr_o = adr_q[NUM_ADDRESS_BITS-1:0];
  assign wb_dat_o = dat_q;
  assign wb_sel_o = 4'hF;
  assign busy_o   = (state_q != CMD0);

endmodule

// File: tb/tb_turf_wb_byte_bridge.sv
// Directed bench for turf_wb_byte_bridge with a hand-driven Wishbone target and response sink.
module tb_turf_wb_byte_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [14:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i, wb_err_i, wb_rty_i;
  logic        busy_o;

  int n_chk  = 0;
  int n_fail = 0;
  int ncyc;

  always #5 clk = ~clk;

  turf_wb_byte_bridge #(.NUM_ADDRESS_BITS(15), .TIMEOUT_CYCLES(16)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .wb_rty_i(wb_rty_i), .busy_o(busy_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int   guard;
    logic rdy;
    guard    = 0;
    s_tdata  = b;
    s_tvalid = 1'b1;
    do begin
      rdy = s_tready;
      tick();
      guard++;
    end while (!rdy && guard < 50);
    if (!rdy) chk("send_timeout", 32'd0, 32'd1);
    s_tvalid = 1'b0;
  endtask

  // term_at: 1-based cycle of wb_cyc_o on which to terminate (0 = never)
  task automatic target(input int term_at, input logic e, input logic r, input logic a,
                        input logic [31:0] d, output int nc);
    nc = 0;
    while (wb_cyc_o && nc < 100) begin
      nc++;
      if (nc == 1) begin
        chk("no_accept_in_wb", {31'd0, s_tready}, 32'd0);
        chk("stb_eq_cyc", {31'd0, wb_stb_o}, 32'd1);
      end
      if (nc == term_at) begin
        wb_err_i = e;
        wb_rty_i = r;
        wb_ack_i = a;
        wb_dat_i = d;
      end
      tick();
      wb_err_i = 1'b0;
      wb_rty_i = 1'b0;
      wb_ack_i = 1'b0;
    end
  endtask

  // mode 1: 1010... sink with a 10-cycle low hold
  task automatic recv(input int n, input logic [39:0] exp, input int mode);
    int         got, i;
    logic       stalled;
    logic [7:0] held;
    got = 0; i = 0; stalled = 1'b0; held = '0;
    while (got < n && i < 200) begin
      m_tready = (mode == 0) ? 1'b1 : ((i >= 3 && i < 13) ? 1'b0 : (i % 2 == 0));
      if (stalled) chk("stable_during_stall", {24'd0, m_tdata}, {24'd0, held});
      chk("no_accept_in_resp", {31'd0, s_tready}, 32'd0);
      if (m_tvalid && m_tready) begin
        chk($sformatf("resp_byte%0d", got), {24'd0, m_tdata}, {24'd0, exp[39-8*got -: 8]});
        got++;
        stalled = 1'b0;
      end else begin
        stalled = m_tvalid;
        held    = m_tdata;
      end
      tick();
      i++;
    end
    m_tready = 1'b1;
    if (got < n) chk("resp_timeout", got, n);
    chk("resp_done_vld", {31'd0, m_tvalid}, 32'd0);
    chk("resp_done_rdy", {31'd0, s_tready}, 32'd1);
    chk("resp_done_busy", {31'd0, busy_o}, 32'd0);
  endtask

  task automatic check_cycle_start(input logic we, input logic [14:0] adr);
    chk("cyc_latency", {31'd0, wb_cyc_o}, 32'd1);
    chk("we", {31'd0, wb_we_o}, {31'd0, we});
    chk("adr", {17'd0, wb_adr_o}, {17'd0, adr});
    chk("sel", {28'd0, wb_sel_o}, 32'hF);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; s_tdata = '0; s_tvalid = 1'b0; m_tready = 1'b1;
    wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
    repeat (3) tick();
    chk("rst_s_tready", {31'd0, s_tready}, 32'd1);
    chk("rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("rst_m_tdata", {24'd0, m_tdata}, 32'd0);
    chk("rst_cyc", {29'd0, wb_cyc_o, wb_stb_o, wb_we_o}, 32'd0);
    chk("rst_adr", {17'd0, wb_adr_o}, 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    rst_n = 1'b1;
    tick();

    // read with ack on the first cyc cycle: minimum latency
    send_byte(8'h00); send_byte(8'h00);
    check_cycle_start(1'b0, 15'h0000);
    chk("busy_in_wb", {31'd0, busy_o}, 32'd1);
    target(1, 1'b0, 1'b0, 1'b1, 32'h54555246, ncyc);
    chk("rd_cyc_len", ncyc, 1);
    chk("rd_status_lat", {31'd0, m_tvalid}, 32'd1);
    recv(5, 40'h00_54555246, 0);

    // write, ack on 3rd cycle
    send_byte(8'h80); send_byte(8'h0C);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    check_cycle_start(1'b1, 15'h000C);
    chk("wr_dat", wb_dat_o, 32'h12345678);
    target(3, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, ncyc);
    chk("wr_cyc_len", ncyc, 3);
    chk("wr_we_drop", {31'd0, wb_we_o}, 32'd0);
    recv(1, 40'h00_00000000, 0);
    chk("dat_hold", wb_dat_o, 32'h12345678);
    chk("adr_hold", {17'd0, wb_adr_o}, 32'h000C);

    // timeout
    send_byte(8'h08); send_byte(8'h04);
    check_cycle_start(1'b0, 15'h0804);
    target(0, 1'b0, 1'b0, 1'b0, 32'h0, ncyc);
    chk("tmo_cyc_len", ncyc, 16);
    recv(5, 40'h03_00000000, 0);

    // next command after timeout
    send_byte(8'h00); send_byte(8'h10);
    check_cycle_start(1'b0, 15'h0010);
    target(2, 1'b0, 1'b0, 1'b1, 32'h01020304, ncyc);
    chk("rd2_cyc_len", ncyc, 2);
    recv(5, 40'h00_01020304, 0);

    // err and ack together: err wins, data zeroed
    send_byte(8'h00); send_byte(8'h04);
    target(2, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, ncyc);
    chk("err_cyc_len", ncyc, 2);
    recv(5, 40'h01_00000000, 0);

    // ack on the timeout-expiry edge
    send_byte(8'h00); send_byte(8'h08);
    target(16, 1'b0, 1'b0, 1'b1, 32'hCAFEF00D, ncyc);
    chk("exp_ack_cyc_len", ncyc, 16);
    recv(5, 40'h00_CAFEF00D, 0);

    // write terminated by retry
    send_byte(8'h81); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    check_cycle_start(1'b1, 15'h0100);
    chk("rty_dat", wb_dat_o, 32'hAABBCCDD);
    target(1, 1'b0, 1'b1, 1'b0, 32'h0, ncyc);
    recv(1, 40'h02_00000000, 0);

    // backpressured read
    send_byte(8'h00); send_byte(8'h00);
    target(1, 1'b0, 1'b0, 1'b1, 32'h54555246, ncyc);
    recv(5, 40'h00_54555246, 1);

    // reset asserted mid-cycle
    send_byte(8'h00); send_byte(8'h00);
    tick(); tick();
    chk("pre_rst_cyc", {31'd0, wb_cyc_o}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_cyc", {31'd0, wb_cyc_o}, 32'd0);
    chk("rst_mid_vld", {31'd0, m_tvalid}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy_o}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_vld", {31'd0, m_tvalid}, 32'd0);
    send_byte(8'h00); send_byte(8'h00);
    check_cycle_start(1'b0, 15'h0000);
    target(1, 1'b0, 1'b0, 1'b1, 32'h54555246, ncyc);
    recv(5, 40'h00_54555246, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
